fp_mul_pipe: RTL and testbench

- Parametrised, fully pipelined IEEE-754-style floating-point multiplier. Successor to the fixed binary32 multiplier.
- Adds configurable exponent/mantissa widths, round-to-nearest-even and exception flags.
- Adds a valid/ready handshake with backpressure and a pass-through tag.
- Sits in a VLIW FP execution slot; the tag carries the destination/slot ID back to writeback.

---
 rtl/fp_pkg.sv | 49 ++++
 rtl/fp_mul_pipe_if.sv | 29 ++
 rtl/fp_round_norm.sv | 49 ++++
 rtl/fp_mul_pipe.sv | 136 +++++++++++++
 tb/tb_fp_mul_pipe.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point constants, field helpers and class encodings
package fp_pkg;

  localparam logic [2:0] CLS_ZERO = 3'd0;
  localparam logic [2:0] CLS_NORM = 3'd1;
  localparam logic [2:0] CLS_INF  = 3'd2;
  localparam logic [2:0] CLS_QNAN = 3'd3;
  localparam logic [2:0] CLS_SNAN = 3'd4;

  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Helpers work on a zero-extended 64-bit word so one set serves every format width.
  function automatic logic [63:0] fp_field_exp(input logic [63:0] x, input int exp_w, input int man_w);
    return (x >> man_w) & ((64'd1 << exp_w) - 64'd1);
  endfunction

  function automatic logic [63:0] fp_field_man(input logic [63:0] x, input int man_w);
    return x & ((64'd1 << man_w) - 64'd1);
  endfunction

  function automatic logic fp_field_sign(input logic [63:0] x, input int exp_w, input int man_w);
    return x[exp_w + man_w];
  endfunction

  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [2:0] fp_classify(input logic [63:0] x, input int exp_w, input int man_w);
    logic [63:0] e;
    logic [63:0] m;
    e = fp_field_exp(x, exp_w, man_w);
    m = fp_field_man(x, man_w);
    if (e == 64'd0)
      return CLS_ZERO;
    else if (e == ((64'd1 << exp_w) - 64'd1))
      return (m == 64'd0) ? CLS_INF : (m[man_w - 1] ? CLS_QNAN : CLS_SNAN);
    else
      return CLS_NORM;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// rtl/fp_mul_pipe_if.sv - operand/result handshake bundle for the pipelined FP multiplier
interface fp_mul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_res;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_flags;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_tag, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_tag, out_flags
  );
endinterface

// File: rtl/fp_round_norm.sv
// rtl/fp_round_norm.sv - normalise, round-to-nearest-even and pack a raw significand product
module fp_round_norm
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [2*MAN_W+1:0]      prod,
  input  logic signed [EXP_W+1:0] exp_in,
  input  logic                    sign,
  output logic [EXP_W+MAN_W:0]    res,
  output logic [3:0]              flags
);
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ONE = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO = EW'(0);

  logic [2*MAN_W+1:0]   norm;
  logic [MAN_W:0]       sig_r;
  logic                 g, s, inc, carry;
  logic signed [EW-1:0] e_n, e_r;

  always_comb begin
    norm  = prod[2*MAN_W+1] ? prod : (prod << 1);
    e_n   = prod[2*MAN_W+1] ? exp_in + E_ONE : exp_in;
    g     = norm[MAN_W];
    s     = |norm[MAN_W-1:0];
    inc   = g & (s | norm[MAN_W+1]);
    // Hidden bit is always 1, so a wrap of the rounded significand to 0 is the carry-out.
    sig_r = norm[2*MAN_W+1:MAN_W+1] + {{MAN_W{1'b0}}, inc};
    carry = ~sig_r[MAN_W];
    e_r   = carry ? e_n + E_ONE : e_n;
    flags = '0;
    res   = '0;
    if (e_r >= EMAX) begin
      res            = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags[FLAG_OF] = 1'b1;
      flags[FLAG_NX] = 1'b1;
    end else if (e_r <= E_ZERO) begin
      res            = {sign, {(EXP_W+MAN_W){1'b0}}};
      flags[FLAG_UF] = 1'b1;
      flags[FLAG_NX] = 1'b1;
    end else begin
      res            = {sign, e_r[EXP_W-1:0], sig_r[MAN_W-1:0]};
      flags[FLAG_NX] = g | s;
    end
  end
endmodule

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - four-stage valid/ready floating-point multiplier with RNE and flags
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  fp_mul_pipe_if.slave io
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2*MAN_W + 2;
  localparam logic [EW-1:0] BIAS_X = EW'(fp_bias(EXP_W));

  logic             advance;
  logic [63:0]      a64, b64;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic [2:0]       cls_a, cls_b;
  logic             sgn, nan_any, snan_any, inf_any, zero_any, inf_zero;
  logic             spec_c;
  logic [W-1:0]     sres_c;
  logic [3:0]       sflg_c;
  logic [EW-1:0]    esum;

  logic                 v1, sign1, spec1;
  logic [TAG_W-1:0]     tag1;
  logic signed [EW-1:0] exp1;
  logic [MAN_W:0]       ma1, mb1;
  logic [W-1:0]         sres1;
  logic [3:0]           sflg1;

  logic                 v2, sign2, spec2;
  logic [TAG_W-1:0]     tag2;
  logic signed [EW-1:0] exp2;
  logic [PW-1:0]        prod2;
  logic [W-1:0]         sres2;
  logic [3:0]           sflg2;

  logic             v3, v4;
  logic [TAG_W-1:0] tag3, tag4;
  logic [W-1:0]     res3, res4, rn_res;
  logic [3:0]       flg3, flg4, rn_flags;

  assign advance = ~v4 | io.out_ready;
  assign a64     = {{(64-W){1'b0}}, io.in_a};
  assign b64     = {{(64-W){1'b0}}, io.in_b};
  assign ea      = EXP_W'(fp_field_exp(a64, EXP_W, MAN_W));
  assign eb      = EXP_W'(fp_field_exp(b64, EXP_W, MAN_W));
  assign fa      = MAN_W'(fp_field_man(a64, MAN_W));
  assign fb      = MAN_W'(fp_field_man(b64, MAN_W));
  assign cls_a   = fp_classify(a64, EXP_W, MAN_W);
  assign cls_b   = fp_classify(b64, EXP_W, MAN_W);
  assign sgn     = fp_field_sign(a64, EXP_W, MAN_W) ^ fp_field_sign(b64, EXP_W, MAN_W);
  assign esum    = {2'b00, ea} + {2'b00, eb} - BIAS_X;

  assign nan_any  = (cls_a == CLS_QNAN) | (cls_a == CLS_SNAN) | (cls_b == CLS_QNAN) | (cls_b == CLS_SNAN);
  assign snan_any = (cls_a == CLS_SNAN) | (cls_b == CLS_SNAN);
  assign inf_any  = (cls_a == CLS_INF) | (cls_b == CLS_INF);
  assign zero_any = (cls_a == CLS_ZERO) | (cls_b == CLS_ZERO);
  assign inf_zero = inf_any & zero_any;

  // Specials are resolved up front and ride alongside the datapath to S3.
  always_comb begin
    spec_c = 1'b1;
    sres_c = '0;
    sflg_c = '0;
    if (nan_any || inf_zero) begin
      sres_c          = W'(fp_qnan(EXP_W, MAN_W));
      sflg_c[FLAG_NV] = snan_any | inf_zero;
    end else if (inf_any) begin
      sres_c = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_any) begin
      sres_c = {sgn, {(W-1){1'b0}}};
    end else begin
      spec_c = 1'b0;
    end
  end

  fp_round_norm #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_norm (
    .prod   (prod2),
    .exp_in (exp2),
    .sign   (sign2),
    .res    (rn_res),
    .flags  (rn_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; sign1 <= 1'b0; spec1 <= 1'b0; tag1 <= '0; exp1 <= '0;
      ma1 <= '0; mb1 <= '0; sres1 <= '0; sflg1 <= '0;
      v2 <= 1'b0; sign2 <= 1'b0; spec2 <= 1'b0; tag2 <= '0; exp2 <= '0;
      prod2 <= '0; sres2 <= '0; sflg2 <= '0;
      v3 <= 1'b0; tag3 <= '0; res3 <= '0; flg3 <= '0;
      v4 <= 1'b0; tag4 <= '0; res4 <= '0; flg4 <= '0;
    end else if (advance) begin
      v1    <= io.in_valid;
      tag1  <= io.in_tag;
      sign1 <= sgn;
      exp1  <= esum;
      ma1   <= {1'b1, fa};
      mb1   <= {1'b1, fb};
      spec1 <= spec_c;
      sres1 <= sres_c;
      sflg1 <= sflg_c;

      v2    <= v1;
      tag2  <= tag1;
      sign2 <= sign1;
      exp2  <= exp1;
      prod2 <= {{(MAN_W+1){1'b0}}, ma1} * {{(MAN_W+1){1'b0}}, mb1};
      spec2 <= spec1;
      sres2 <= sres1;
      sflg2 <= sflg1;

      v3   <= v2;
      tag3 <= tag2;
      res3 <= spec2 ? sres2 : rn_res;
      flg3 <= spec2 ? sflg2 : rn_flags;

      v4   <= v3;
      tag4 <= tag3;
      res4 <= res3;
      flg4 <= flg3;
    end
  end

  assign io.in_ready  = advance;
  assign io.out_valid = v4;
  assign io.out_res   = res4;
  assign io.out_tag   = tag4;
  assign io.out_flags = flg4;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - directed self-checking bench for fp_mul_pipe (binary32 and 5/10 formats)
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) if32 ();
  fp_mul_pipe_if #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) if16 ();

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut32 (.clk(clk), .rst_n(rst_n), .io(if32));
  fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut16 (.clk(clk), .rst_n(rst_n), .io(if16));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sample(input bit half, output logic v, output logic [31:0] r,
                        output logic [3:0] t, output logic [3:0] f);
    if (half) begin
      v = if16.out_valid; r = {16'd0, if16.out_res}; t = if16.out_tag; f = if16.out_flags;
    end else begin
      v = if32.out_valid; r = if32.out_res; t = if32.out_tag; f = if32.out_flags;
    end
  endtask

  task automatic run_op(input string name, input bit half, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic [31:0] er, input logic [3:0] ef,
                        output int lat);
    logic v;
    logic [31:0] r;
    logic [3:0] t, f;
    @(negedge clk);
    if (half) begin
      if16.in_a = a[15:0]; if16.in_b = b[15:0]; if16.in_tag = tag; if16.in_valid = 1'b1;
    end else begin
      if32.in_a = a; if32.in_b = b; if32.in_tag = tag; if32.in_valid = 1'b1;
    end
    @(negedge clk);
    if16.in_valid = 1'b0;
    if32.in_valid = 1'b0;
    lat = 1;
    sample(half, v, r, t, f);
    while (!v && lat < 20) begin
      @(negedge clk);
      lat++;
      sample(half, v, r, t, f);
    end
    check({name, ".valid"}, 64'(v), 64'd1);
    check({name, ".res"}, 64'(r), 64'(er));
    check({name, ".tag"}, 64'(t), 64'(tag));
    check({name, ".flags"}, 64'(f), 64'(ef));
  endtask

  string       vn [15] = '{"basic", "rne_sticky", "exact", "tie_odd", "tie_even", "carry", "neg",
                           "inf_zero", "qnan", "snan", "neg_inf", "subnorm", "overflow", "underflow",
                           "neg_zero"};
  logic [31:0] va [15] = '{32'h3FC00000, 32'h3F800001, 32'h3F800003, 32'h3FC00000, 32'h3FC00000,
                           32'h3FFFFFFE, 32'hBFC00000, 32'h7F800000, 32'h7FC00000, 32'h7F800001,
                           32'hFF800000, 32'h00000001, 32'h7F000000, 32'h00800000, 32'h80000000};
  logic [31:0] vb [15] = '{32'h40000000, 32'h3F800001, 32'h3F800000, 32'h3F800001, 32'h3F800003,
                           32'h3F800001, 32'h40000000, 32'h00000000, 32'h3F800000, 32'h3F800000,
                           32'h40000000, 32'h40000000, 32'h7F000000, 32'h00800000, 32'h3F800000};
  logic [31:0] vr [15] = '{32'h40400000, 32'h3F800002, 32'h3F800003, 32'h3FC00002, 32'h3FC00004,
                           32'h40000000, 32'hC0400000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
                           32'hFF800000, 32'h00000000, 32'h7F800000, 32'h00000000, 32'h80000000};
  logic [3:0]  vf [15] = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h8, 4'h0, 4'h8,
                           4'h0, 4'h0, 4'h5, 4'h3, 4'h0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int sent;
    int rcv;
    int extra;
    rst_n = 1'b0;
    if32.in_valid = 1'b0; if32.in_a = '0; if32.in_b = '0; if32.in_tag = '0; if32.out_ready = 1'b1;
    if16.in_valid = 1'b0; if16.in_a = '0; if16.in_b = '0; if16.in_tag = '0; if16.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset.out_valid", 64'(if32.out_valid), 64'd0);
    check("reset.out_res", 64'(if32.out_res), 64'd0);
    check("reset.out_tag", 64'(if32.out_tag), 64'd0);
    check("reset.out_flags", 64'(if32.out_flags), 64'd0);
    check("reset.in_ready", 64'(if32.in_ready), 64'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_op(vn[i], 1'b0, va[i], vb[i], 4'(i + 3), vr[i], vf[i], lat);
      if (i == 0) check("latency", 64'(lat), 64'd4);
    end

    run_op("h_basic", 1'b1, 32'h3E00, 32'h4000, 4'd9, 32'h4200, 4'h0, lat);
    run_op("h_overflow", 1'b1, 32'h7800, 32'h7800, 4'd10, 32'h7C00, 4'h5, lat);

    // Back-to-back stream of 8 ops with a 3-cycle output stall in the middle.
    sent = 0;
    rcv = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if32.out_ready = !(c >= 6 && c <= 8);
      if (sent < 8) begin
        if32.in_valid = 1'b1;
        if32.in_a = 32'h3F800000 | 32'(sent);
        if32.in_b = 32'h40000000;
        if32.in_tag = 4'(sent);
      end else begin
        if32.in_valid = 1'b0;
      end
      #1;
      if (c >= 6 && c <= 8) begin
        check("bp.stall_valid", 64'(if32.out_valid), 64'd1);
        check("bp.in_ready_low", 64'(if32.in_ready), 64'd0);
      end
      if (if32.out_valid && rcv < 8) begin
        check("bp.tag", 64'(if32.out_tag), 64'(rcv));
        check("bp.res", 64'(if32.out_res), 64'(32'h40000000 | 32'(rcv)));
        check("bp.flags", 64'(if32.out_flags), 64'd0);
        if (if32.out_ready) rcv++;
      end else if (if32.out_valid) begin
        check("bp.extra_result", 64'd1, 64'd0);
      end
      if (if32.in_valid && if32.in_ready) sent++;
    end
    if32.in_valid = 1'b0;
    if32.out_ready = 1'b1;
    check("bp.sent", 64'(sent), 64'd8);
    check("bp.received", 64'(rcv), 64'd8);

    // Asynchronous reset with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if32.in_valid = 1'b1; if32.in_a = 32'h3FC00000; if32.in_b = 32'h40000000; if32.in_tag = 4'(i);
    end
    @(negedge clk);
    if32.in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("rst.pre_valid", 64'(if32.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst.out_valid", 64'(if32.out_valid), 64'd0);
    check("rst.out_res", 64'(if32.out_res), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (if32.out_valid) extra++;
    end
    check("rst.residual", 64'(extra), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
